// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter for the shared memory port
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   order_req/address         instruction-fetch request (held until order_cplt)
//   order_rdata, order_cplt   fetched word (held) and one-cycle completion pulse
//   data_rw/size/address/wdata data request: rw 2 = read, 3 = write, 0/1 = idle
//   data_rdata, data_cplt     read data (held) and one-cycle completion pulse
//   mem_rw/size/address/wdata registered memory command, constant while busy
//   mem_rdata, mem_cplt       memory read data and one-cycle completion pulse
//   bus_err                   pulses with *_cplt when a transaction timed out
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        order_req,
  input  logic [31:0] order_address,
  output logic [31:0] order_rdata,
  output logic        order_cplt,
  input  logic [1:0]  data_rw,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_address,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_cplt,
  output logic [1:0]  mem_rw,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_cplt,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_O = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  // A zero TIMEOUT disables the abort path entirely.
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [15:0] LIMIT      = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      state, state_d;
  grant_t      last_grant;
  logic [15:0] cnt;

  logic fetch_req, data_req;
  logic grant_fetch, grant_data;
  logic finish, abort;
  logic busy;

  assign fetch_req = order_req;
  assign data_req  = data_rw[1];
  assign busy      = (state == BUSY_O) || (state == BUSY_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        // Fetch wins when alone, or when both ask and data went last.
        if (fetch_req && (!data_req || last_grant == GRANT_DATA)) begin
          grant_fetch = 1'b1;
          state_d     = BUSY_O;
        end else if (data_req) begin
          grant_data = 1'b1;
          state_d    = BUSY_D;
        end
      end
      BUSY_O, BUSY_D: begin
        // A completion on the limit cycle takes priority over the abort.
        if (mem_cplt) begin
          finish  = 1'b1;
          state_d = RESP;
        end else if (TIMEOUT_EN && cnt == LIMIT) begin
          finish  = 1'b1;
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= GRANT_DATA;
      cnt         <= 16'd0;
      mem_rw      <= 2'd0;
      mem_size    <= 2'd0;
      mem_address <= 32'd0;
      mem_wdata   <= 32'd0;
      order_rdata <= 32'd0;
      data_rdata  <= 32'd0;
      order_cplt  <= 1'b0;
      data_cplt   <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      order_cplt <= 1'b0;
      data_cplt  <= 1'b0;
      bus_err    <= 1'b0;

      if (grant_fetch) begin
        mem_rw      <= 2'd2;
        mem_size    <= 2'd3;
        mem_address <= order_address;
        mem_wdata   <= 32'd0;
        last_grant  <= GRANT_FETCH;
        cnt         <= 16'd0;
      end

      if (grant_data) begin
        mem_rw      <= data_rw;
        mem_size    <= data_size;
        mem_address <= data_address;
        mem_wdata   <= data_wdata;
        last_grant  <= GRANT_DATA;
        cnt         <= 16'd0;
      end

      if (busy && !finish) begin
        cnt <= cnt + 16'd1;
      end

      if (finish) begin
        mem_rw  <= 2'd0;
        bus_err <= abort;
        // mem_rw[0] is clear for reads; writes leave rdata untouched.
        if (state == BUSY_O) begin
          order_cplt <= 1'b1;
          if (!mem_rw[0]) begin
            order_rdata <= abort ? 32'hFFFF_FFFF : mem_rdata;
          end
        end else begin
          data_cplt <= 1'b1;
          if (!mem_rw[0]) begin
            data_rdata <= abort ? 32'hFFFF_FFFF : mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        order_req = 1'b0;
  logic [31:0] order_address = 32'd0;
  logic [31:0] order_rdata;
  logic        order_cplt;
  logic [1:0]  data_rw = 2'd0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_address = 32'd0;
  logic [31:0] data_wdata = 32'd0;
  logic [31:0] data_rdata;
  logic        data_cplt;
  logic [1:0]  mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_cplt = 1'b0;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .order_req(order_req), .order_address(order_address),
    .order_rdata(order_rdata), .order_cplt(order_cplt),
    .data_rw(data_rw), .data_size(data_size), .data_address(data_address),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_cplt(data_cplt),
    .mem_rw(mem_rw), .mem_size(mem_size), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_cplt(mem_cplt),
    .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (mem_rw !== 2'd0) begin errors++; $display("FAIL reset_mem_rw got %0d exp 0", mem_rw); end
    checks++; if (mem_size !== 2'd0) begin errors++; $display("FAIL reset_mem_size got %0d exp 0", mem_size); end
    checks++; if (mem_address !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_addr_wdata got %h/%h exp 0/0", mem_address, mem_wdata); end
    checks++; if (order_rdata !== 32'd0 || data_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", order_rdata, data_rdata); end
    checks++; if ({order_cplt, data_cplt, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {order_cplt, data_cplt, bus_err}); end
  endtask

  task automatic test_single_fetch();
    order_req = 1'b1;
    order_address = 32'h100;
    tick();
    checks++; if (mem_rw !== 2'd2 || mem_size !== 2'd3) begin errors++; $display("FAIL fetch_cmd got rw %0d size %0d exp 2/3", mem_rw, mem_size); end
    checks++; if (mem_address !== 32'h100 || mem_wdata !== 32'd0) begin errors++; $display("FAIL fetch_addr got %h/%h exp 100/0", mem_address, mem_wdata); end
    tick();
    checks++; if (mem_rw !== 2'd2 || order_cplt !== 1'b0) begin errors++; $display("FAIL fetch_busy got rw %0d cplt %b exp 2/0", mem_rw, order_cplt); end
    mem_cplt = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_cplt = 1'b0;
    checks++; if (order_cplt !== 1'b1 || order_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_resp got cplt %b rdata %h exp 1/deadbeef", order_cplt, order_rdata); end
    checks++; if (data_cplt !== 1'b0 || bus_err !== 1'b0 || mem_rw !== 2'd0) begin errors++; $display("FAIL fetch_side got dcplt %b err %b rw %0d exp 0/0/0", data_cplt, bus_err, mem_rw); end
    order_req = 1'b0;
    tick();
    checks++; if (order_cplt !== 1'b0 || order_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_pulse_width got cplt %b rdata %h exp 0/deadbeef", order_cplt, order_rdata); end
  endtask

  task automatic test_simultaneous();
    int i;
    bit exp_fetch;
    test_reset();
    order_req = 1'b1;
    order_address = 32'h400;
    data_rw = 2'd2;
    data_size = 2'd3;
    data_address = 32'h800;
    for (int n = 1; n <= 12; n++) begin
      tick();
      i = (n - 1) / 3;
      exp_fetch = (i % 2 == 0);
      if (n % 3 == 1) begin
        checks++; if (mem_rw !== 2'd2 || mem_address !== (exp_fetch ? 32'h400 : 32'h800)) begin errors++; $display("FAIL rr_grant%0d got rw %0d addr %h exp 2/%h", i, mem_rw, mem_address, exp_fetch ? 32'h400 : 32'h800); end
        mem_cplt = 1'b1;
        mem_rdata = 32'h1000 + i;
      end else if (n % 3 == 2) begin
        mem_cplt = 1'b0;
        checks++; if (order_cplt !== exp_fetch || data_cplt !== !exp_fetch) begin errors++; $display("FAIL rr_cplt%0d got o %b d %b exp o %b", i, order_cplt, data_cplt, exp_fetch); end
        checks++; if ((exp_fetch ? order_rdata : data_rdata) !== 32'h1000 + i) begin errors++; $display("FAIL rr_rdata%0d got %h/%h exp %h", i, order_rdata, data_rdata, 32'h1000 + i); end
        if (n == 11) begin
          order_req = 1'b0;
          data_rw = 2'd0;
        end
      end else begin
        checks++; if (order_cplt !== 1'b0 || data_cplt !== 1'b0 || mem_rw !== 2'd0) begin errors++; $display("FAIL rr_idle%0d got o %b d %b rw %0d exp 0/0/0", n, order_cplt, data_cplt, mem_rw); end
      end
    end
  endtask

  task automatic test_data_write();
    data_rw = 2'd3;
    data_size = 2'd1;
    data_address = 32'h2000;
    data_wdata = 32'h1234;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (mem_rw !== 2'd3 || mem_size !== 2'd1 || mem_address !== 32'h2000 || mem_wdata !== 32'h1234) begin errors++; $display("FAIL write_hold%0d got %0d %0d %h %h exp 3 1 2000 1234", c, mem_rw, mem_size, mem_address, mem_wdata); end
      if (c == 1) data_wdata = 32'hFFFF;
      if (c == 3) begin
        mem_cplt = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
      end
    end
    tick();
    mem_cplt = 1'b0;
    checks++; if (data_cplt !== 1'b1 || bus_err !== 1'b0 || order_cplt !== 1'b0) begin errors++; $display("FAIL write_cplt got d %b err %b o %b exp 1/0/0", data_cplt, bus_err, order_cplt); end
    checks++; if (data_rdata !== 32'h1003) begin errors++; $display("FAIL write_rdata got %h exp 00001003", data_rdata); end
    data_rw = 2'd0;
    data_wdata = 32'd0;
    tick();
    checks++; if (data_cplt !== 1'b0 || mem_rw !== 2'd0) begin errors++; $display("FAIL write_after got d %b rw %0d exp 0/0", data_cplt, mem_rw); end
  endtask

  task automatic test_timeout();
    data_rw = 2'd2;
    data_size = 2'd3;
    data_address = 32'h3000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if (mem_rw !== 2'd2 || data_cplt !== 1'b0) begin errors++; $display("FAIL tmo_busy%0d got rw %0d cplt %b exp 2/0", c, mem_rw, data_cplt); end
    end
    tick();
    checks++; if (data_cplt !== 1'b1 || bus_err !== 1'b1) begin errors++; $display("FAIL tmo_abort got cplt %b err %b exp 1/1", data_cplt, bus_err); end
    checks++; if (data_rdata !== 32'hFFFFFFFF || mem_rw !== 2'd0) begin errors++; $display("FAIL tmo_rdata got %h rw %0d exp ffffffff/0", data_rdata, mem_rw); end
    data_rw = 2'd0;
    tick();
    checks++; if (data_cplt !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL tmo_after got cplt %b err %b exp 0/0", data_cplt, bus_err); end
    data_rw = 2'd2;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if (mem_rw !== 2'd2 || data_cplt !== 1'b0) begin errors++; $display("FAIL edge_busy%0d got rw %0d cplt %b exp 2/0", c, mem_rw, data_cplt); end
      if (c == 8) begin
        mem_cplt = 1'b1;
        mem_rdata = 32'h55AA1234;
      end
    end
    tick();
    mem_cplt = 1'b0;
    checks++; if (data_cplt !== 1'b1 || bus_err !== 1'b0 || data_rdata !== 32'h55AA1234) begin errors++; $display("FAIL edge_cplt got cplt %b err %b rdata %h exp 1/0/55aa1234", data_cplt, bus_err, data_rdata); end
    data_rw = 2'd0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    data_rw = 2'd2;
    data_address = 32'h3100;
    tick();
    checks++; if (mem_rw !== 2'd2 || mem_address !== 32'h3100) begin errors++; $display("FAIL rstmid_busy got rw %0d addr %h exp 2/3100", mem_rw, mem_address); end
    rst = 1'b1;
    data_rw = 2'd0;
    tick();
    rst = 1'b0;
    checks++; if (mem_rw !== 2'd0 || mem_size !== 2'd0 || mem_address !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL rstmid_mem got %0d %0d %h %h exp zeros", mem_rw, mem_size, mem_address, mem_wdata); end
    checks++; if (order_rdata !== 32'd0 || data_rdata !== 32'd0 || {order_cplt, data_cplt, bus_err} !== 3'b000) begin errors++; $display("FAIL rstmid_out got %h %h %b exp zeros", order_rdata, data_rdata, {order_cplt, data_cplt, bus_err}); end
    tick();
    mem_cplt = 1'b1;
    mem_rdata = 32'h12121212;
    tick();
    mem_cplt = 1'b0;
    checks++; if (data_cplt !== 1'b0 || order_cplt !== 1'b0 || data_rdata !== 32'd0 || mem_rw !== 2'd0) begin errors++; $display("FAIL rstmid_late got d %b o %b rdata %h rw %0d exp 0/0/0/0", data_cplt, order_cplt, data_rdata, mem_rw); end
    order_req = 1'b1;
    order_address = 32'h500;
    tick();
    checks++; if (mem_rw !== 2'd2 || mem_address !== 32'h500) begin errors++; $display("FAIL rstmid_fetch got rw %0d addr %h exp 2/500", mem_rw, mem_address); end
    mem_cplt = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    tick();
    mem_cplt = 1'b0;
    order_req = 1'b0;
    checks++; if (order_cplt !== 1'b1 || order_rdata !== 32'hCAFEF00D || bus_err !== 1'b0) begin errors++; $display("FAIL rstmid_resp got cplt %b rdata %h err %b exp 1/cafef00d/0", order_cplt, order_rdata, bus_err); end
    tick();
  endtask

  task automatic test_stale_cplt();
    mem_cplt = 1'b1;
    mem_rdata = 32'h77777777;
    tick();
    mem_cplt = 1'b0;
    checks++; if (mem_rw !== 2'd0 || order_cplt !== 1'b0 || data_cplt !== 1'b0) begin errors++; $display("FAIL stale_idle got rw %0d o %b d %b exp 0/0/0", mem_rw, order_cplt, data_cplt); end
    checks++; if (order_rdata !== 32'hCAFEF00D || data_rdata !== 32'd0) begin errors++; $display("FAIL stale_idle_rdata got %h/%h exp cafef00d/0", order_rdata, data_rdata); end
    order_req = 1'b1;
    order_address = 32'h600;
    tick();
    mem_cplt = 1'b1;
    mem_rdata = 32'h00600600;
    tick();
    order_req = 1'b0;
    checks++; if (order_cplt !== 1'b1 || order_rdata !== 32'h00600600) begin errors++; $display("FAIL stale_fetch got cplt %b rdata %h exp 1/00600600", order_cplt, order_rdata); end
    mem_cplt = 1'b1;
    mem_rdata = 32'h99999999;
    tick();
    mem_cplt = 1'b0;
    checks++; if (order_cplt !== 1'b0 || order_rdata !== 32'h00600600 || mem_rw !== 2'd0 || bus_err !== 1'b0) begin errors++; $display("FAIL stale_resp got cplt %b rdata %h rw %0d err %b exp 0/00600600/0/0", order_cplt, order_rdata, mem_rw, bus_err); end
    tick();
    checks++; if (order_cplt !== 1'b0 || data_cplt !== 1'b0 || mem_rw !== 2'd0) begin errors++; $display("FAIL stale_after got o %b d %b rw %0d exp 0/0/0", order_cplt, data_cplt, mem_rw); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_data_write();
    test_timeout();
    test_reset_mid_busy();
    test_stale_cplt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
